// File: rtl/regfile_read_unit_pkg.sv
// Shared definitions for the register-file read side.
//   NREG_DEF / WIDTH_DEF / AW_DEF : default geometry (32 x 32-bit, 5-bit address)
//   dump_state_t                  : debug dump engine states
package regfile_read_unit_pkg;

    localparam int NREG_DEF  = 32;
    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SEND = 2'd2,
        DUMP_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_read_unit_mux.sv
// Combinational register value selector v(a).
//   i_regs_flat : storage contents, reg i at [i*WIDTH +: WIDTH]
//   i_wr_en     : storage write in progress (bypass source)
//   i_wr_addr   : storage write address
//   i_wr_data   : storage write data
//   i_addr      : register to read
//   o_data      : 0 for $0, forwarded write data on address match, else stored value
module regfile_read_mux
    import regfile_read_unit_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [NREG*WIDTH-1:0] i_regs_flat,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [AW-1:0]         i_addr,
    output logic [WIDTH-1:0]      o_data
);

    logic [WIDTH-1:0] w_array;

    always_comb begin
        w_array = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (i_addr == AW'(i)) begin
                w_array = i_regs_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // $0 check comes first so a write targeting $0 is never forwarded.
    always_comb begin
        o_data = '0;
        if (i_addr == '0) begin
            o_data = '0;
        end else if (i_wr_en && (i_wr_addr == i_addr)) begin
            o_data = i_wr_data;
        end else begin
            o_data = w_array;
        end
    end

endmodule

// File: rtl/regfile_read_unit.sv
// Read side of the register file: two registered operand ports with
// write bypass and hardwired $0, plus a debug engine that streams every
// register out over valid/ready.
//   clk, clr                 : clock, async active-low reset
//   regs_flat                : storage contents
//   wr_en/wr_addr/wr_data    : storage write in progress (bypass source)
//   rd_en/rs_addr/rt_addr    : operand read request
//   rs_data/rt_data/rd_valid : registered operands, valid for one cycle
//   dump_start/dump_ready    : dump trigger pulse, downstream accept
//   dump_valid/addr/data     : dump beat
//   dump_busy/dump_done      : engine active, completion pulse
module regfile_read_unit
    import regfile_read_unit_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREG*WIDTH-1:0] regs_flat,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rs_addr,
    input  logic [AW-1:0]         rt_addr,
    output logic [WIDTH-1:0]      rs_data,
    output logic [WIDTH-1:0]      rt_data,
    output logic                  rd_valid,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [AW-1:0]         dump_addr,
    output logic [WIDTH-1:0]      dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [WIDTH-1:0] w_rs_val;
    logic [WIDTH-1:0] w_rt_val;
    logic [WIDTH-1:0] w_dump_val;

    dump_state_t      r_state;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic             r_rd_valid;
    logic             r_dump_valid;
    logic [AW-1:0]    r_dump_addr;
    logic [WIDTH-1:0] r_dump_data;
    logic             r_dump_done;

    regfile_read_mux #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) u_mux_rs (
        .i_regs_flat (regs_flat),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_addr      (rs_addr),
        .o_data      (w_rs_val)
    );

    regfile_read_mux #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) u_mux_rt (
        .i_regs_flat (regs_flat),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_addr      (rt_addr),
        .o_data      (w_rt_val)
    );

    regfile_read_mux #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) u_mux_dump (
        .i_regs_flat (regs_flat),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_addr      (r_idx),
        .o_data      (w_dump_val)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= DUMP_IDLE;
            r_idx        <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_done  <= 1'b0;
        end else begin
            // Operand port: data holds when no request.
            if (rd_en) begin
                r_rs_data  <= w_rs_val;
                r_rt_data  <= w_rt_val;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end

            case (r_state)
                DUMP_IDLE: begin
                    r_dump_done <= 1'b0;
                    if (dump_start) begin
                        r_idx   <= '0;
                        r_state <= DUMP_LOAD;
                    end
                end
                DUMP_LOAD: begin
                    r_dump_data  <= w_dump_val;
                    r_dump_addr  <= r_idx;
                    r_dump_valid <= 1'b1;
                    r_state      <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (r_dump_valid && dump_ready) begin
                        r_dump_valid <= 1'b0;
                        // Last-index test before increment keeps idx from wrapping.
                        if (r_idx == LAST_IDX) begin
                            r_dump_done <= 1'b1;
                            r_state     <= DUMP_DONE;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= DUMP_LOAD;
                        end
                    end
                end
                DUMP_DONE: begin
                    r_dump_done <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= DUMP_IDLE;
                end
                default: begin
                    r_state <= DUMP_IDLE;
                end
            endcase
        end
    end

    assign rs_data    = r_rs_data;
    assign rt_data    = r_rt_data;
    assign rd_valid   = r_rd_valid;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_done  = r_dump_done;
    assign dump_busy  = (r_state != DUMP_IDLE);

endmodule

// File: tb/tb_regfile_read_unit.sv
// Randomized self-checking bench for regfile_read_unit against a
// behavioural model: a register array, the value rule v(a), and a
// dump scoreboard built from a snapshot of the registers.
module tb_regfile_read_unit;

    localparam int NREG  = 32;
    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  clr = 1'b0;
    logic [NREG*WIDTH-1:0] regs_flat;
    logic                  wr_en = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [WIDTH-1:0]      wr_data = '0;
    logic                  rd_en = 1'b0;
    logic [AW-1:0]         rs_addr = '0;
    logic [AW-1:0]         rt_addr = '0;
    logic [WIDTH-1:0]      rs_data;
    logic [WIDTH-1:0]      rt_data;
    logic                  rd_valid;
    logic                  dump_start = 1'b0;
    logic                  dump_ready = 1'b1;
    logic                  dump_valid;
    logic [AW-1:0]         dump_addr;
    logic [WIDTH-1:0]      dump_data;
    logic                  dump_busy;
    logic                  dump_done;

    logic [WIDTH-1:0] regs_m  [NREG];
    logic [WIDTH-1:0] dump_exp[NREG];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int exp_beat  = 0;
    int done_count = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    logic mon_en  = 1'b0;
    logic prev_stall = 1'b0;
    logic [AW-1:0]    prev_addr = '0;
    logic [WIDTH-1:0] prev_data = '0;

    regfile_read_unit #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .clr        (clr),
        .regs_flat  (regs_flat),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .rd_valid   (rd_valid),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) regs_flat[i*WIDTH +: WIDTH] = regs_m[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Register value as seen by a reader this cycle.
    function automatic logic [WIDTH-1:0] v(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return regs_m[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dump scoreboard: beats must arrive in order 0..NREG-1 with the
    // register values present when the dump started; a stalled beat
    // must not change.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, dump_valid}, 32'd1);
                chk("hold_addr", {27'd0, dump_addr}, {27'd0, prev_addr});
                chk("hold_data", dump_data, prev_data);
            end
            if (dump_valid && dump_ready) begin
                if (exp_beat < NREG) begin
                    chk("beat_addr", {27'd0, dump_addr}, exp_beat);
                    chk("beat_data", dump_data, dump_exp[exp_beat]);
                end else begin
                    chk("extra_beat", exp_beat, NREG - 1);
                end
                exp_beat = exp_beat + 1;
            end
            if (dump_done) begin
                done_count = done_count + 1;
                done_cyc   = cyc;
            end
            prev_stall <= dump_valid && !dump_ready;
            prev_addr  <= dump_addr;
            prev_data  <= dump_data;
        end
    end

    task automatic start_dump();
        for (int i = 0; i < NREG; i++) dump_exp[i] = (i == 0) ? '0 : regs_m[i];
        exp_beat   = 0;
        mon_en     = 1'b1;
        dump_start = 1'b1;
        step();
        start_cyc  = cyc;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int n = 0;
        while (done_count == prev && n < budget) begin
            step();
            n++;
        end
        if (done_count == prev) chk("dump_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rs"}, rs_data, 0);
        chk({tag, "_rt"}, rt_data, 0);
        chk({tag, "_rdv"}, {31'd0, rd_valid}, 0);
        chk({tag, "_dv"}, {31'd0, dump_valid}, 0);
        chk({tag, "_da"}, {27'd0, dump_addr}, 0);
        chk({tag, "_dd"}, dump_data, 0);
        chk({tag, "_busy"}, {31'd0, dump_busy}, 0);
        chk({tag, "_done"}, {31'd0, dump_done}, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] e_rs;
        logic [WIDTH-1:0] e_rt;
        logic             e_v;
        int prev_done;
        int stall3;
        int n;
        logic pulsed;

        for (int i = 0; i < NREG; i++) regs_m[i] = '0;

        // Reset state
        #3;
        check_all_zero("reset");
        step();
        step();
        clr = 1'b1;
        step();

        // Directed read with $0 on rt
        regs_m[5] = 32'hDEADBEEF;
        rd_en = 1'b1; rs_addr = 5'd5; rt_addr = 5'd0;
        step();
        chk("rd_rs5", rs_data, 32'hDEADBEEF);
        chk("rd_rt0", rt_data, 32'h0);
        chk("rd_valid1", {31'd0, rd_valid}, 1);
        rd_en = 1'b0;
        step();
        chk("rd_valid_drop", {31'd0, rd_valid}, 0);
        chk("rd_hold", rs_data, 32'hDEADBEEF);

        // Bypass, and no bypass into $0
        regs_m[7] = '0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_en = 1'b1; rs_addr = 5'd7; rt_addr = 5'd7;
        step();
        chk("byp_rs7", rs_data, 32'h12345678);
        chk("byp_rt7", rt_data, 32'h12345678);
        wr_addr = 5'd0; rs_addr = 5'd0;
        step();
        chk("byp_rs0", rs_data, 32'h0);
        wr_en = 1'b0; rd_en = 1'b0;
        step();

        // Randomized operand reads
        e_rs = rs_data; e_rt = rt_data;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) regs_m[$urandom_range(0, NREG-1)] = $urandom;
            rd_en   = ($urandom_range(0, 3) != 0);
            rs_addr = AW'($urandom_range(0, NREG-1));
            rt_addr = ($urandom_range(0, 7) == 0) ? rs_addr : AW'($urandom_range(0, NREG-1));
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = ($urandom_range(0, 1) == 1) ? rs_addr : AW'($urandom_range(0, NREG-1));
            wr_data = $urandom;
            e_v = rd_en;
            if (rd_en) begin
                e_rs = v(rs_addr);
                e_rt = v(rt_addr);
            end
            step();
            chk("rnd_valid", {31'd0, rd_valid}, {31'd0, e_v});
            chk("rnd_rs", rs_data, e_rs);
            chk("rnd_rt", rt_data, e_rt);
        end
        rd_en = 1'b0; wr_en = 1'b0;
        step();

        // Full dump, no back-pressure; done appears 64 edges after the start edge
        for (int i = 0; i < NREG; i++) regs_m[i] = 32'(i * 32'h11);
        dump_ready = 1'b1;
        prev_done = done_count;
        start_dump();
        chk("busy_after_start", {31'd0, dump_busy}, 1);
        wait_done(prev_done, 200);
        step();
        chk("dump4_beats", exp_beat, NREG);
        chk("dump4_done_once", done_count, prev_done + 1);
        chk("dump4_latency", done_cyc - start_cyc, 64);
        chk("dump4_idle", {31'd0, dump_busy}, 0);

        // Back-pressure on beat 3, random stalls, ignored restart, late write
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        prev_done = done_count;
        start_dump();
        stall3 = 0; pulsed = 1'b0; n = 0;
        while (done_count == prev_done && n < 600) begin
            dump_start = 1'b0;
            wr_en = 1'b0;
            if (dump_valid && dump_addr == 5'd3 && stall3 < 5) begin
                dump_ready = 1'b0;
                if (stall3 == 0) begin
                    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A50003;
                    regs_m[3] = 32'h0BAD0003;
                end
                stall3++;
            end else begin
                dump_ready = ($urandom_range(0, 3) != 0);
            end
            if (!pulsed && exp_beat == 8) begin
                dump_start = 1'b1;
                pulsed = 1'b1;
            end
            step();
            n++;
        end
        dump_start = 1'b0; wr_en = 1'b0; dump_ready = 1'b1;
        if (done_count == prev_done) chk("dump5_timeout", 32'd0, 32'd1);
        step(); step();
        chk("dump5_stall_len", stall3, 5);
        chk("dump5_beats", exp_beat, NREG);
        chk("dump5_done_once", done_count, prev_done + 1);
        chk("dump5_idle", {31'd0, dump_busy}, 0);

        // Abort during beat 10, then restart from 0
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        prev_done = done_count;
        start_dump();
        n = 0;
        while (!(dump_valid && dump_addr == 5'd10) && n < 100) begin
            step();
            n++;
        end
        chk("abort_reached10", {31'd0, dump_valid && dump_addr == 5'd10}, 1);
        mon_en = 1'b0;
        clr = 1'b0;
        #1;
        check_all_zero("abort");
        step();
        clr = 1'b1;
        for (int k = 0; k < 80; k++) step();
        chk("abort_no_done", done_count, prev_done);
        chk("abort_idle", {31'd0, dump_busy}, 0);
        chk("abort_no_valid", {31'd0, dump_valid}, 0);
        start_dump();
        wait_done(prev_done, 200);
        step();
        chk("restart_beats", exp_beat, NREG);
        chk("restart_done_once", done_count, prev_done + 1);
        chk("restart_latency", done_cyc - start_cyc, 64);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
